thresholding_axilite_cfg: RTL and testbench
===========================================

Name: thresholding_axilite_cfg

Overview:
- AXI4-Lite slave that turns host register accesses into single-cycle accesses on the threshold configuration port (cfg_en/cfg_we/cfg_a/cfg_d, with cfg_rack/cfg_q for readback).
- Sits directly upstream of the thresholding core's configuration port.
- Drives at most one configuration access per cycle.
- Holds each readback until the core's fixed-latency cfg_rack returns, then presents it on the R channel.

Parameters:
- CFG_A_BITS, 8, width of cfg_a; equals $clog2(CF)+$clog2(PE)+N of the core.
- K, 16, threshold width; 1 <= K <= 32.
- SIGNED, 1, sign-extend readback data to 32 bits; 0 zero-extends.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_axilite_awvalid/awready  in/out  1  write address handshake.
- s_axilite_awaddr  in  CFG_A_BITS+2  byte address; bits [1:0] ignored.
- s_axilite_wvalid/wready  in/out  1  write data handshake.
- s_axilite_wdata  in  32  write data; [K-1:0] used.
- s_axilite_wstrb  in  4  ignored; every write is a full word.
- s_axilite_bvalid/bready  out/in  1  write response handshake.
- s_axilite_bresp  out  2  constant 2'b00 (OKAY).
- s_axilite_arvalid/arready  in/out  1  read address handshake.
- s_axilite_araddr  in  CFG_A_BITS+2  byte address; bits [1:0] ignored.
- s_axilite_rvalid/rready  out/in  1  read data handshake.
- s_axilite_rdata  out  32  readback value, extended per SIGNED.
- s_axilite_rresp  out  2  constant 2'b00.
- cfg_en, cfg_we  out  1  configuration strobe and write enable.
- cfg_a  out  CFG_A_BITS  word address, equal to axaddr[CFG_A_BITS+1:2].
- cfg_d  out  K  write data, equal to wdata[K-1:0]; 0 on reads.
- cfg_rack  in  1  readback valid, one cycle, fixed latency after the RB issue.
- cfg_q  in  K  readback value, valid while cfg_rack is high.

Behaviour:
- Reset values: all ready/valid outputs 0 except awready, wready, arready = 1; cfg_en = 0; priority flag = write.
- Write path:
  - AW and W are captured independently into holding registers.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - The channels may arrive in either order or in the same cycle.
  - Issue condition: aw_held && w_held && grant. In the issue cycle cfg_en = 1, cfg_we = 1.
  - Next cycle: bvalid = 1 and both holding registers clear.
  - bvalid drops on bready; awready and wready return in that same cycle as seen by the next edge.
  - Only one write is in flight at a time.
- Read path, FSM R_IDLE -> R_ISSUE -> R_WAIT -> R_RESP -> R_IDLE:
  - R_IDLE: arready = 1; an AR handshake latches the address and moves to R_ISSUE.
  - R_ISSUE: when granted, cfg_en = 1 and cfg_we = 0 for one cycle; move to R_WAIT.
  - R_WAIT: on cfg_rack, register the extended cfg_q into rdata and move to R_RESP.
  - R_RESP: rvalid = 1 and rdata is stable until rready.
  - Only one read is in flight at a time. There is no timeout; R_WAIT waits indefinitely.
- Arbitration (cfg_en is asserted for at most one access per cycle):
  - If only one side requests, it is granted.
  - If both request, the side not granted last wins; the priority flag then flips to the loser.
  - Writes may issue while a read sits in R_WAIT; pipeline ordering keeps results correct.
- cfg_a and cfg_d are don't-care (driven 0) when cfg_en = 0.
- cfg_rack outside R_WAIT is ignored. This covers stray racks and a rack arriving after a mid-operation reset.
- Reset mid-operation discards all captured addresses/data and any pending B or R; no response is issued for them.
- Readback latency (AR handshake at t, core readback latency L): cfg_en at t+1 when ungranted-free, cfg_rack at t+1+L, rvalid at t+2+L.
- Write latency: last of AW/W handshake at t, cfg_en at t+1, bvalid at t+2.

Decomposition:
- Shared package thresholding_pkg holds:
  - AXILITE_RESP_OKAY = 2'b00;
  - the read FSM enum (R_IDLE, R_ISSUE, R_WAIT, R_RESP);
  - a function deriving CFG_A_BITS from N, C, PE, shared with the core instantiation.
- No sub-module: the arbiter is a single flag and is kept inline.

Test Plan:
- Write: AW 0x0004 and W 0x0000_0123 in the same cycle -> one cfg_en cycle with cfg_we = 1, cfg_a = 1, cfg_d = 0x123 (K = 16); bvalid two cycles later, bresp = 0.
- Skewed write: W 0x55 at cycle 0, AW 0x0008 at cycle 5 -> cfg_en at cycle 6 with cfg_a = 2; wready stays low during cycles 1-5.
- Signed readback: AR 0x0004, stub returns cfg_rack with cfg_q = 0x8001 after 5 cycles -> rdata = 0xFFFF_8001 and rvalid held through 3 cycles of rready = 0; with SIGNED = 0, rdata = 0x0000_8001.
- Conflict: write ready and read in R_ISSUE in the same cycle after reset -> write granted first, read granted the next cycle; a repeat of the conflict grants the read first.
- Stray rack: cfg_rack pulse in R_IDLE -> no rvalid. Reset asserted during R_WAIT, then a rack arrives -> no rvalid, arready = 1.
- Back-to-back: 16 writes then 16 readbacks against a behavioural memory stub -> all rdata values match, never more than one cfg_en per cycle.

Source files
------------

// File: rtl/thresholding_pkg.sv
// Shared definitions for the thresholding core and its AXI4-Lite configuration front end.
package thresholding_pkg;

  localparam logic [1:0] AXILITE_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_WAIT  = 2'd2,
    R_RESP  = 2'd3
  } rdState_e;

  // Width of the core's configuration word address: channel fold, PE select and threshold index.
  function automatic int calcCfgABits(input int n, input int c, input int pe);
    return $clog2(c / pe) + $clog2(pe) + n;
  endfunction

endpackage

// File: rtl/thresholding_axilite_cfg_if.sv
// AXI4-Lite bus bundle between a host (master) and the thresholding configuration slave.
interface thresholding_axilite_cfg_if #(
  parameter int ADDR_BITS = 10
) ();

  logic                 awvalid;
  logic                 awready;
  logic [ADDR_BITS-1:0] awaddr;
  logic                 wvalid;
  logic                 wready;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 bvalid;
  logic                 bready;
  logic [1:0]           bresp;
  logic                 arvalid;
  logic                 arready;
  logic [ADDR_BITS-1:0] araddr;
  logic                 rvalid;
  logic                 rready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/thresholding_axilite_cfg.sv
// AXI4-Lite slave that turns host register accesses into single-cycle accesses on the
// thresholding core's configuration port, holding readbacks until the core's cfg_rack.
module thresholding_axilite_cfg
  import thresholding_pkg::*;
#(
  parameter int CFG_A_BITS = 8,
  parameter int K          = 16,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  thresholding_axilite_cfg_if.slave s_axilite,
  output logic                     cfg_en,
  output logic                     cfg_we,
  output logic [CFG_A_BITS-1:0]    cfg_a,
  output logic [K-1:0]             cfg_d,
  input  logic                     cfg_rack,
  input  logic [K-1:0]             cfg_q
);

  logic                  r_awHeld;
  logic                  r_wHeld;
  logic                  r_bvalid;
  logic [CFG_A_BITS-1:0] r_awAddr;
  logic [K-1:0]          r_wData;
  logic [CFG_A_BITS-1:0] r_arAddr;
  logic [31:0]           r_rdata;
  logic                  r_prioWrite;
  rdState_e              r_rdState;
  rdState_e              w_rdStateNext;

  logic                  w_awReady;
  logic                  w_wReady;
  logic                  w_arReady;
  logic                  w_rvalid;
  logic                  w_wrReq;
  logic                  w_rdReq;
  logic                  w_wrGrant;
  logic                  w_rdGrant;
  logic [31:0]           w_qExt;
  logic                  w_unused;

  // Byte-lane strobes and the sub-word address bits carry no meaning for this port.
  assign w_unused = ^{s_axilite.wstrb, s_axilite.awaddr[1:0], s_axilite.araddr[1:0], s_axilite.wdata};

  // A channel stops accepting once its half is captured or a response is still owed.
  assign w_awReady = !r_awHeld && !r_bvalid;
  assign w_wReady  = !r_wHeld && !r_bvalid;

  // Arbitration: a lone requester always wins; on a tie the flag picks the side that lost last time.
  assign w_wrReq   = r_awHeld && r_wHeld;
  assign w_wrGrant = w_wrReq && (!w_rdReq || r_prioWrite);
  assign w_rdGrant = w_rdReq && (!w_wrReq || !r_prioWrite);

  // Readback is widened to the 32-bit bus either by sign or by zero extension.
  assign w_qExt = SIGNED ? 32'(signed'(cfg_q)) : 32'(cfg_q);

  // Capture AW and W independently, release both when the write is issued, then owe a B response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_awHeld <= 1'b0;
      r_wHeld  <= 1'b0;
      r_bvalid <= 1'b0;
      r_awAddr <= '0;
      r_wData  <= '0;
    end else begin
      if (s_axilite.awvalid && w_awReady) begin
        r_awHeld <= 1'b1;
        r_awAddr <= s_axilite.awaddr[CFG_A_BITS+1:2];
      end else if (w_wrGrant) begin
        r_awHeld <= 1'b0;
      end
      if (s_axilite.wvalid && w_wReady) begin
        r_wHeld <= 1'b1;
        r_wData <= s_axilite.wdata[K-1:0];
      end else if (w_wrGrant) begin
        r_wHeld <= 1'b0;
      end
      if (w_wrGrant) begin
        r_bvalid <= 1'b1;
      end else if (s_axilite.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Priority flag only moves on a genuine conflict, and then it points at the loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prioWrite <= 1'b1;
    end else if (w_wrReq && w_rdReq) begin
      r_prioWrite <= w_rdGrant;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdState <= R_IDLE;
    end else begin
      r_rdState <= w_rdStateNext;
    end
  end

  // Read FSM next state: accept, issue when granted, wait for the core, hand back to the host.
  always_comb begin
    w_rdStateNext = r_rdState;
    case (r_rdState)
      R_IDLE:  if (s_axilite.arvalid) w_rdStateNext = R_ISSUE;
      R_ISSUE: if (w_rdGrant)         w_rdStateNext = R_WAIT;
      R_WAIT:  if (cfg_rack)          w_rdStateNext = R_RESP;
      R_RESP:  if (s_axilite.rready)  w_rdStateNext = R_IDLE;
      default:                        w_rdStateNext = R_IDLE;
    endcase
  end

  // Read FSM outputs decoded from the current state.
  always_comb begin
    w_arReady = 1'b0;
    w_rvalid  = 1'b0;
    w_rdReq   = 1'b0;
    case (r_rdState)
      R_IDLE:  w_arReady = 1'b1;
      R_ISSUE: w_rdReq   = 1'b1;
      R_RESP:  w_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // Read address latch and readback capture; racks outside R_WAIT are stale and dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arAddr <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_rdState == R_IDLE && s_axilite.arvalid) begin
        r_arAddr <= s_axilite.araddr[CFG_A_BITS+1:2];
      end
      if (r_rdState == R_WAIT && cfg_rack) begin
        r_rdata <= w_qExt;
      end
    end
  end

  // Configuration port drive: address and data are forced to zero whenever no access is issued.
  always_comb begin
    cfg_en = w_wrGrant || w_rdGrant;
    cfg_we = w_wrGrant;
    cfg_a  = '0;
    cfg_d  = '0;
    if (w_wrGrant) begin
      cfg_a = r_awAddr;
      cfg_d = r_wData;
    end else if (w_rdGrant) begin
      cfg_a = r_arAddr;
    end
  end

  assign s_axilite.awready = w_awReady;
  assign s_axilite.wready  = w_wReady;
  assign s_axilite.bvalid  = r_bvalid;
  assign s_axilite.bresp   = AXILITE_RESP_OKAY;
  assign s_axilite.arready = w_arReady;
  assign s_axilite.rvalid  = w_rvalid;
  assign s_axilite.rdata   = r_rdata;
  assign s_axilite.rresp   = AXILITE_RESP_OKAY;

endmodule

// File: tb/tb_thresholding_axilite_cfg.sv
// Directed bench for thresholding_axilite_cfg: a signed and an unsigned instance share one
// host stimulus and one behavioural configuration-memory stub with a fixed readback latency.
module tb_thresholding_axilite_cfg;
  import thresholding_pkg::*;

  localparam int CFG_A_BITS = 8;
  localparam int K          = 16;
  localparam int ADDR_BITS  = CFG_A_BITS + 2;
  localparam int RB_LAT     = 5;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  expCfgA;
    logic [15:0] expCfgD;
    logic [31:0] expSigned;
    logic [31:0] expUnsigned;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thresholding_axilite_cfg_if #(.ADDR_BITS(ADDR_BITS)) axiS ();
  thresholding_axilite_cfg_if #(.ADDR_BITS(ADDR_BITS)) axiU ();

  // The unsigned instance sees exactly the same host traffic as the signed one.
  assign axiU.awvalid = axiS.awvalid;
  assign axiU.awaddr  = axiS.awaddr;
  assign axiU.wvalid  = axiS.wvalid;
  assign axiU.wdata   = axiS.wdata;
  assign axiU.wstrb   = axiS.wstrb;
  assign axiU.bready  = axiS.bready;
  assign axiU.arvalid = axiS.arvalid;
  assign axiU.araddr  = axiS.araddr;
  assign axiU.rready  = axiS.rready;

  logic        cfgEn, cfgWe;
  logic [7:0]  cfgA;
  logic [15:0] cfgD;
  logic        unusedEnU, unusedWeU;
  logic [7:0]  unusedAU;
  logic [15:0] unusedDU;
  logic        cfgRack, stubRack, tbRack;
  logic [15:0] cfgQ, stubQ, tbQ;

  assign cfgRack = stubRack | tbRack;
  assign cfgQ    = tbRack ? tbQ : stubQ;

  thresholding_axilite_cfg #(.CFG_A_BITS(CFG_A_BITS), .K(K), .SIGNED(1'b1)) dutS (
    .clk(clk), .rst(rst), .s_axilite(axiS.slave),
    .cfg_en(cfgEn), .cfg_we(cfgWe), .cfg_a(cfgA), .cfg_d(cfgD),
    .cfg_rack(cfgRack), .cfg_q(cfgQ)
  );

  thresholding_axilite_cfg #(.CFG_A_BITS(CFG_A_BITS), .K(K), .SIGNED(1'b0)) dutU (
    .clk(clk), .rst(rst), .s_axilite(axiU.slave),
    .cfg_en(unusedEnU), .cfg_we(unusedWeU), .cfg_a(unusedAU), .cfg_d(unusedDU),
    .cfg_rack(cfgRack), .cfg_q(cfgQ)
  );

  // Behavioural core configuration memory: readback returns RB_LAT cycles after the issue.
  logic [15:0]       mem [256];
  logic [RB_LAT-1:0] rbPipe = '0;
  logic [15:0]       qPipe [RB_LAT];
  always @(posedge clk) begin
    if (cfgEn && cfgWe) mem[cfgA] <= cfgD;
    rbPipe   <= {rbPipe[RB_LAT-2:0], cfgEn && !cfgWe};
    qPipe[0] <= mem[cfgA];
    for (int i = 1; i < RB_LAT; i++) qPipe[i] <= qPipe[i-1];
  end
  assign stubRack = rbPipe[RB_LAT-1];
  assign stubQ    = qPipe[RB_LAT-1];

  // Port monitor: counts issued accesses and idle cycles where address/data are not zero.
  int enCount = 0;
  int idleViolations = 0;
  always @(negedge clk) begin
    if (cfgEn) enCount++;
    else if (cfgA !== 8'h00 || cfgD !== 16'h0000) idleViolations++;
  end

  int nChecks = 0;
  int nFail   = 0;
  vec_t vecs [16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic axiWrite(input logic [9:0] addr, input logic [31:0] data,
                          output logic [7:0] seenA, output logic [15:0] seenD, output int seenEn);
    logic awPend, wPend, bDone, awGo, wGo, bGo;
    int n;
    seenA = '0; seenD = '0; seenEn = 0;
    axiS.awaddr = addr; axiS.wdata = data; axiS.wstrb = 4'hF;
    axiS.awvalid = 1'b1; axiS.wvalid = 1'b1; axiS.bready = 1'b1;
    awPend = 1'b1; wPend = 1'b1; bDone = 1'b0; n = 0;
    while (!bDone && n < 40) begin
      awGo = awPend && axiS.awready;
      wGo  = wPend && axiS.wready;
      bGo  = axiS.bvalid;
      @(negedge clk);
      n++;
      if (awGo) begin awPend = 1'b0; axiS.awvalid = 1'b0; end
      if (wGo)  begin wPend = 1'b0;  axiS.wvalid = 1'b0;  end
      if (bGo) bDone = 1'b1;
      if (cfgEn && cfgWe) begin seenEn++; seenA = cfgA; seenD = cfgD; end
    end
    axiS.awvalid = 1'b0; axiS.wvalid = 1'b0;
    checkOutput("wr_complete", 32'(bDone), 32'd1);
  endtask

  task automatic axiRead(input logic [9:0] addr, output logic [31:0] dataS, output logic [31:0] dataU);
    logic arPend, rDone, arGo, rGo;
    int n;
    dataS = '0; dataU = '0;
    axiS.araddr = addr; axiS.arvalid = 1'b1; axiS.rready = 1'b1;
    arPend = 1'b1; rDone = 1'b0; n = 0;
    while (!rDone && n < 40) begin
      arGo = arPend && axiS.arready;
      rGo  = axiS.rvalid;
      if (rGo) begin dataS = axiS.rdata; dataU = axiU.rdata; end
      @(negedge clk);
      n++;
      if (arGo) begin arPend = 1'b0; axiS.arvalid = 1'b0; end
      if (rGo) rDone = 1'b1;
    end
    axiS.arvalid = 1'b0;
    checkOutput("rd_complete", 32'(rDone), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (!(axiS.arready && axiS.awready && !axiS.bvalid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n < 40), 32'd1);
  endtask

  // One table entry: full write, checking the single issued access it produced.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] sa; logic [15:0] sd; int se;
    axiWrite(v.addr, v.wdata, sa, sd, se);
    checkOutput($sformatf("b2b_wr%0d_en_count", idx), 32'(se), 32'd1);
    checkOutput($sformatf("b2b_wr%0d_cfg_a", idx), 32'(sa), 32'(v.expCfgA));
    checkOutput($sformatf("b2b_wr%0d_cfg_d", idx), 32'(sd), 32'(v.expCfgD));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  sa;
    logic [15:0] sd;
    int          se, n, enBefore;
    logic [31:0] rdS, rdU;
    logic        sawRvalid, sawRack;

    vecs[0]  = '{10'h000, 32'h0000_0000, 8'h00, 16'h0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{10'h004, 32'h0000_1234, 8'h01, 16'h1234, 32'h0000_1234, 32'h0000_1234};
    vecs[2]  = '{10'h00B, 32'h0000_7FFF, 8'h02, 16'h7FFF, 32'h0000_7FFF, 32'h0000_7FFF};
    vecs[3]  = '{10'h010, 32'h0000_8000, 8'h04, 16'h8000, 32'hFFFF_8000, 32'h0000_8000};
    vecs[4]  = '{10'h3FC, 32'h0000_FFFF, 8'hFF, 16'hFFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
    vecs[5]  = '{10'h3FB, 32'hABCD_5A5A, 8'hFE, 16'h5A5A, 32'h0000_5A5A, 32'h0000_5A5A};
    vecs[6]  = '{10'h200, 32'hFFFF_0001, 8'h80, 16'h0001, 32'h0000_0001, 32'h0000_0001};
    vecs[7]  = '{10'h1FC, 32'h0000_C3C3, 8'h7F, 16'hC3C3, 32'hFFFF_C3C3, 32'h0000_C3C3};
    vecs[8]  = '{10'h020, 32'h1234_0000, 8'h08, 16'h0000, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{10'h044, 32'h0000_0F0F, 8'h11, 16'h0F0F, 32'h0000_0F0F, 32'h0000_0F0F};
    vecs[10] = '{10'h088, 32'h0000_A5A5, 8'h22, 16'hA5A5, 32'hFFFF_A5A5, 32'h0000_A5A5};
    vecs[11] = '{10'h111, 32'h0000_4000, 8'h44, 16'h4000, 32'h0000_4000, 32'h0000_4000};
    vecs[12] = '{10'h222, 32'h8000_8001, 8'h88, 16'h8001, 32'hFFFF_8001, 32'h0000_8001};
    vecs[13] = '{10'h155, 32'h0000_0100, 8'h55, 16'h0100, 32'h0000_0100, 32'h0000_0100};
    vecs[14] = '{10'h2AA, 32'h0000_FFFE, 8'hAA, 16'hFFFE, 32'hFFFF_FFFE, 32'h0000_FFFE};
    vecs[15] = '{10'h0FC, 32'h5555_7777, 8'h3F, 16'h7777, 32'h0000_7777, 32'h0000_7777};

    axiS.awvalid = 1'b0; axiS.awaddr = '0; axiS.wvalid = 1'b0; axiS.wdata = '0; axiS.wstrb = 4'hF;
    axiS.bready = 1'b0; axiS.arvalid = 1'b0; axiS.araddr = '0; axiS.rready = 1'b0;
    tbRack = 1'b0; tbQ = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_awready", 32'(axiS.awready), 32'd1);
    checkOutput("rst_wready",  32'(axiS.wready),  32'd1);
    checkOutput("rst_arready", 32'(axiS.arready), 32'd1);
    checkOutput("rst_bvalid",  32'(axiS.bvalid),  32'd0);
    checkOutput("rst_rvalid",  32'(axiS.rvalid),  32'd0);
    checkOutput("rst_cfg_en",  32'(cfgEn),        32'd0);

    $display("[TB] same-cycle write");
    axiS.awvalid = 1'b1; axiS.awaddr = 10'h004; axiS.wvalid = 1'b1; axiS.wdata = 32'h0000_0123;
    @(negedge clk);
    axiS.awvalid = 1'b0; axiS.wvalid = 1'b0;
    checkOutput("wr_same_cfg_en", 32'(cfgEn), 32'd1);
    checkOutput("wr_same_cfg_we", 32'(cfgWe), 32'd1);
    checkOutput("wr_same_cfg_a",  32'(cfgA),  32'h01);
    checkOutput("wr_same_cfg_d",  32'(cfgD),  32'h0123);
    checkOutput("wr_same_bvalid_early", 32'(axiS.bvalid), 32'd0);
    checkOutput("wr_same_awready_busy", 32'(axiS.awready), 32'd0);
    @(negedge clk);
    checkOutput("wr_same_cfg_en_off", 32'(cfgEn), 32'd0);
    checkOutput("wr_same_bvalid", 32'(axiS.bvalid), 32'd1);
    checkOutput("wr_same_bresp",  32'(axiS.bresp),  32'(AXILITE_RESP_OKAY));
    axiS.bready = 1'b1;
    @(negedge clk);
    axiS.bready = 1'b0;
    checkOutput("wr_same_bvalid_drop", 32'(axiS.bvalid),  32'd0);
    checkOutput("wr_same_awready_back", 32'(axiS.awready), 32'd1);
    checkOutput("wr_same_wready_back",  32'(axiS.wready),  32'd1);

    $display("[TB] skewed write");
    axiS.wvalid = 1'b1; axiS.wdata = 32'h0000_0055;
    @(negedge clk);
    axiS.wvalid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("skew_wready_c%0d", i), 32'(axiS.wready), 32'd0);
      checkOutput($sformatf("skew_cfg_en_c%0d", i), 32'(cfgEn), 32'd0);
      if (i == 5) begin axiS.awvalid = 1'b1; axiS.awaddr = 10'h008; end
      @(negedge clk);
    end
    axiS.awvalid = 1'b0;
    checkOutput("skew_cfg_en", 32'(cfgEn), 32'd1);
    checkOutput("skew_cfg_a",  32'(cfgA),  32'h02);
    checkOutput("skew_cfg_d",  32'(cfgD),  32'h0055);
    axiS.bready = 1'b1;
    @(negedge clk);
    checkOutput("skew_bvalid", 32'(axiS.bvalid), 32'd1);
    @(negedge clk);
    axiS.bready = 1'b0;
    checkOutput("skew_bvalid_drop", 32'(axiS.bvalid), 32'd0);

    $display("[TB] signed readback");
    axiWrite(10'h004, 32'h0000_8001, sa, sd, se);
    axiS.bready = 1'b0;
    checkOutput("rb_arready", 32'(axiS.arready), 32'd1);
    axiS.araddr = 10'h004; axiS.arvalid = 1'b1;
    @(negedge clk);
    axiS.arvalid = 1'b0;
    checkOutput("rb_cfg_en", 32'(cfgEn), 32'd1);
    checkOutput("rb_cfg_we", 32'(cfgWe), 32'd0);
    checkOutput("rb_cfg_a",  32'(cfgA),  32'h01);
    checkOutput("rb_cfg_d",  32'(cfgD),  32'h0000);
    n = 0;
    while (!axiS.rvalid && n < 20) begin @(negedge clk); n++; end
    checkOutput("rb_latency", 32'(n), 32'(RB_LAT + 1));
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rb_hold%0d_rvalid", i), 32'(axiS.rvalid), 32'd1);
      checkOutput($sformatf("rb_hold%0d_rdata_s", i), axiS.rdata, 32'hFFFF_8001);
      checkOutput($sformatf("rb_hold%0d_rdata_u", i), axiU.rdata, 32'h0000_8001);
      @(negedge clk);
    end
    checkOutput("rb_rresp", 32'(axiS.rresp), 32'(AXILITE_RESP_OKAY));
    axiS.rready = 1'b1;
    @(negedge clk);
    axiS.rready = 1'b0;
    checkOutput("rb_rvalid_drop", 32'(axiS.rvalid), 32'd0);
    checkOutput("rb_arready_back", 32'(axiS.arready), 32'd1);

    $display("[TB] write/read conflict");
    doReset();
    for (int rep = 0; rep < 2; rep++) begin
      axiS.awvalid = 1'b1; axiS.awaddr = 10'h00C; axiS.wvalid = 1'b1; axiS.wdata = 32'h0000_0777;
      axiS.arvalid = 1'b1; axiS.araddr = 10'h004; axiS.bready = 1'b1; axiS.rready = 1'b1;
      @(negedge clk);
      axiS.awvalid = 1'b0; axiS.wvalid = 1'b0; axiS.arvalid = 1'b0;
      checkOutput($sformatf("conflict%0d_first_en", rep), 32'(cfgEn), 32'd1);
      checkOutput($sformatf("conflict%0d_first_we", rep), 32'(cfgWe), (rep == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      checkOutput($sformatf("conflict%0d_second_en", rep), 32'(cfgEn), 32'd1);
      checkOutput($sformatf("conflict%0d_second_we", rep), 32'(cfgWe), (rep == 0) ? 32'd0 : 32'd1);
      waitIdle($sformatf("conflict%0d_drain", rep));
    end

    $display("[TB] stray rack and reset during wait");
    tbQ = 16'h1111; tbRack = 1'b1;
    @(negedge clk);
    tbRack = 1'b0;
    sawRvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sawRvalid |= axiS.rvalid;
      @(negedge clk);
    end
    checkOutput("stray_no_rvalid", 32'(sawRvalid), 32'd0);
    checkOutput("stray_arready", 32'(axiS.arready), 32'd1);
    axiS.araddr = 10'h004; axiS.arvalid = 1'b1;
    @(negedge clk);
    axiS.arvalid = 1'b0;
    checkOutput("rstwait_cfg_en", 32'(cfgEn), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sawRvalid = 1'b0; sawRack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sawRvalid |= axiS.rvalid;
      sawRack   |= cfgRack;
      @(negedge clk);
    end
    checkOutput("rstwait_rack_seen", 32'(sawRack), 32'd1);
    checkOutput("rstwait_no_rvalid", 32'(sawRvalid), 32'd0);
    checkOutput("rstwait_arready", 32'(axiS.arready), 32'd1);

    $display("[TB] back-to-back table");
    enBefore = enCount;
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);
    for (int i = 0; i < 16; i++) begin
      axiRead(vecs[i].addr, rdS, rdU);
      checkOutput($sformatf("b2b_rd%0d_signed", i), rdS, vecs[i].expSigned);
      checkOutput($sformatf("b2b_rd%0d_unsigned", i), rdU, vecs[i].expUnsigned);
    end
    checkOutput("b2b_total_cfg_en", 32'(enCount - enBefore), 32'd32);
    checkOutput("idle_cfg_a_d_zero", 32'(idleViolations), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
